// File: rtl/pll_sync_pack_pkg.sv
// Shared definitions for the PLL-sync family: phase-lock state encoding and
// the lane-index width used by the fast-to-slow packers.
package pll_sync_pack_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } sync_state_t;

    // One bit wider than the lane count needs, so the index can grow safely.
    function automatic int lane_idx_width(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

endpackage

// File: rtl/pll_sync_pack.sv
// Packs RATIO fast-domain samples into one slow-period word, presented on the
// update phase of an externally generated phase counter.
module pll_sync_pack
    import pll_sync_pack_pkg::*;
#(
    parameter int RATIO   = 8,
    parameter int WIDTH   = 12,
    parameter int UPD_CTR = RATIO / 2
) (
    input  logic                       fst_clk,
    input  logic                       rst_n,
    input  logic [$clog2(RATIO)-1:0]   ctr,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_valid,
    output logic [RATIO*WIDTH-1:0]     dout,
    output logic                       dout_valid,
    output logic [7:0]                 dout_seq,
    output logic                       overflow
);

    localparam int CW = $clog2(RATIO);
    localparam int IW = lane_idx_width(RATIO);
    localparam int WW = RATIO * WIDTH;

    sync_state_t     state_reg = SYNC;
    sync_state_t     state_next;
    logic [IW-1:0]   idx_reg = '0;
    logic [IW-1:0]   idx_next;
    logic [WW-1:0]   asm_reg = '0;
    logic [WW-1:0]   asm_next;
    logic [WW-1:0]   pend_word_reg = '0;
    logic [WW-1:0]   pend_word_next;
    logic            pend_reg = 1'b0;
    logic            pend_next;
    logic [WW-1:0]   dout_reg = '0;
    logic [WW-1:0]   dout_next;
    logic            dout_valid_reg = 1'b0;
    logic            dout_valid_next;
    logic [7:0]      seq_reg = '0;
    logic [7:0]      seq_next;
    logic            ovf_reg = 1'b0;
    logic            ovf_next;

    logic            upd_edge;
    logic            wr_en;
    logic            complete;
    logic [RATIO-1:0] lane_wr;

    assign upd_edge = (state_reg == RUN) && (ctr == CW'(UPD_CTR));
    assign wr_en    = (state_reg == RUN) && din_valid;
    assign complete = wr_en && (idx_reg == IW'(RATIO - 1));

    // asm_next already carries the sample being written this edge, so on
    // completion it is the full word.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        assign lane_wr[gi] = wr_en && (idx_reg == IW'(gi));
        assign asm_next[gi*WIDTH +: WIDTH] =
            lane_wr[gi] ? din : asm_reg[gi*WIDTH +: WIDTH];
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        pend_word_next  = pend_word_reg;
        pend_next       = pend_reg;
        dout_next       = dout_reg;
        dout_valid_next = dout_valid_reg;
        seq_next        = seq_reg;
        ovf_next        = ovf_reg;

        case (state_reg)
            SYNC:    if (ctr == CW'(UPD_CTR)) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = SYNC;
        endcase

        if (wr_en) begin
            idx_next = complete ? '0 : idx_reg + IW'(1);
        end

        if (upd_edge) begin
            if (pend_reg) begin
                dout_next       = pend_word_reg;
                dout_valid_next = 1'b1;
                seq_next        = seq_reg + 8'd1;
                pend_next       = 1'b0;
            end else begin
                dout_valid_next = 1'b0;
            end
        end

        // An update edge frees the pending slot on the same edge it refills.
        if (complete) begin
            if (!pend_reg || upd_edge) begin
                pend_word_next = asm_next;
                pend_next      = 1'b1;
            end else begin
                ovf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge fst_clk) begin
        if (!rst_n) begin
            state_reg      <= SYNC;
            idx_reg        <= '0;
            asm_reg        <= '0;
            pend_word_reg  <= '0;
            pend_reg       <= 1'b0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            seq_reg        <= '0;
            ovf_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            asm_reg        <= asm_next;
            pend_word_reg  <= pend_word_next;
            pend_reg       <= pend_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            seq_reg        <= seq_next;
            ovf_reg        <= ovf_next;
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign dout_seq   = seq_reg;
    assign overflow   = ovf_reg;

endmodule

// File: doc/pll_sync_pack.md
PLL_SYNC_PACK -- requirements
Module: pll_sync_pack

Interface
REQ-001 SHALL have parameter RATIO, default 8, slow-to-fast clock period ratio; power of 2, at least 4.
REQ-002 SHALL have parameter WIDTH, default 12, sample width in bits.
REQ-003 SHALL have parameter UPD_CTR, default RATIO/2, phase-counter value on which outputs update.
REQ-004 SHALL have port fst_clk  input  1  fast clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port ctr  input  $clog2(RATIO)  phase counter from the upstream phase-counter stage; 0 at slow edge, increments per fast cycle, wraps at RATIO-1.
REQ-007 SHALL have port din  input  WIDTH  fast-domain sample.
REQ-008 SHALL have port din_valid  input  1  din qualifier.
REQ-009 SHALL have port dout  output  RATIO*WIDTH  packed word; lane 0 (LSBs) = oldest sample.
REQ-010 SHALL have port dout_valid  output  1  dout holds a new word for the current slow period.
REQ-011 SHALL have port dout_seq  output  8  count of words emitted, mod 256.
REQ-012 SHALL have port overflow  output  1  sticky; a completed word was dropped.

Function
REQ-013 SHALL implement states SYNC and RUN; reset enters SYNC.
REQ-014 In SYNC, SHALL ignore din_valid and move to RUN on the first edge with ctr == UPD_CTR.
REQ-015 In RUN, each edge with din_valid=1 SHALL write din into assembly lane idx and increment idx, where idx is the $clog2(RATIO)+1-bit index.
REQ-016 When the write fills lane RATIO-1, SHALL set idx to 0 and mark the word complete on that same edge.
REQ-017 On completion with pending=0, SHALL copy the word to the pending register and set pending=1.
REQ-018 On completion with pending=1 and no update edge that cycle, SHALL drop the new word, keep the old pending word and set overflow.
REQ-019 On an update edge (RUN and ctr == UPD_CTR), if pending=1: SHALL load dout from pending, set dout_valid=1, increment dout_seq (wrap 255->0) and clear pending.
REQ-020 On an update edge with pending=0, SHALL hold dout and clear dout_valid.
REQ-021 If completion and an update edge coincide, SHALL emit the old pending word and load the new word into pending; no overflow.
REQ-022 SHALL NOT bypass a completed word directly to dout; the minimum latency from the last-sample edge to dout change is 1 update edge after pending is set.
REQ-023 dout, dout_valid and dout_seq SHALL change only on update edges, so they are stable for RATIO fast cycles around each slow edge.
REQ-024 SHALL keep a partial word across update edges; idx SHALL wrap only on completion.
REQ-025 overflow SHALL stay set until reset.

Reset
REQ-026 rst_n=0 on an edge SHALL set dout=0, dout_valid=0, dout_seq=0, overflow=0, pending=0, idx=0, state=SYNC; the partial word is discarded.
REQ-027 Reset mid-word or mid-period SHALL need no drain; after release, behaviour restarts from REQ-014.
REQ-028 All registers SHALL also have matching initial values for FPGA power-up.

Structure
REQ-029 The state encoding (SYNC/RUN) and the lane-index width function SHALL live in the shared package used by the PLL-sync family.
REQ-030 SHALL be a single module with no sub-modules; the phase counter is generated externally and is not instantiated here.

Verification
REQ-031 Reset, then 8 consecutive valid samples 1..8 after SYNC exits -> at the next ctr==4 edge, dout lanes0..7 = 1..8, dout_valid=1, dout_seq=1.
REQ-032 Continuous din_valid=1 over 4 slow periods -> one word per period, dout_valid=1 every period, dout_seq 1,2,3,4, overflow=0.
REQ-033 Samples fed before the first ctr==4 edge -> ignored; the first word contains only post-SYNC samples.
REQ-034 din_valid asserted 2 of every 3 cycles -> dout_valid pattern has periods with 0, no partial words emitted, lane order preserved across gaps.
REQ-035 Force ctr to stick at 0 (no update edges) while 16 samples arrive -> first word pending, second word dropped, overflow=1; after ctr resumes, the emitted word equals the first word.
REQ-036 rst_n=0 for 1 cycle after 5 samples of a word -> all outputs 0; the next emitted word starts with the first post-reset sample.
